// File: rtl/hsv_core_ctrlstatus_regs_arbiter.sv
// Two-requester arbiter for the CSR register-file bus.
// m0 = CSR instruction unit, m1 = trap/commit path. One outstanding access at a
// time; responses are steered back to the owner, and a missing downstream ack
// is converted into an error response after ACK_TIMEOUT cycles in WAIT.
module hsv_core_ctrlstatus_regs_arbiter #(
  parameter int unsigned M1_PRIORITY = 1,
  parameter int unsigned ACK_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk_core,
  input  logic        rst_core,

  input  logic        m0_req,
  input  logic        m0_req_is_wr,
  input  logic [15:0] m0_addr,
  input  logic [31:0] m0_wr_data,
  input  logic [31:0] m0_wr_biten,
  output logic        m0_req_stall_rd,
  output logic        m0_req_stall_wr,
  output logic        m0_rd_ack,
  output logic        m0_rd_err,
  output logic [31:0] m0_rd_data,
  output logic        m0_wr_ack,
  output logic        m0_wr_err,

  input  logic        m1_req,
  input  logic        m1_req_is_wr,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m1_wr_data,
  input  logic [31:0] m1_wr_biten,
  output logic        m1_req_stall_rd,
  output logic        m1_req_stall_wr,
  output logic        m1_rd_ack,
  output logic        m1_rd_err,
  output logic [31:0] m1_rd_data,
  output logic        m1_wr_ack,
  output logic        m1_wr_err,

  output logic        regs_req,
  output logic        regs_req_is_wr,
  output logic [15:0] regs_addr,
  output logic [31:0] regs_wr_data,
  output logic [31:0] regs_wr_biten,
  input  logic        regs_req_stall_rd,
  input  logic        regs_req_stall_wr,
  input  logic        regs_rd_ack,
  input  logic        regs_rd_err,
  input  logic [31:0] regs_rd_data,
  input  logic        regs_wr_ack,
  input  logic        regs_wr_err,

  output logic        grant,
  output logic        busy,
  output logic        spurious_ack
);

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam bit          TO_EN  = (ACK_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  typedef struct packed {
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] wr_biten;
  } req_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state;
  logic              grant_q;
  logic              last_grant;
  logic              txn_is_wr;
  logic [CNT_W-1:0]  cnt;

  req_t              m0_pl;
  req_t              m1_pl;
  req_t              sel_pl;
  logic              sel_req;
  logic              win;
  logic              accept;
  logic              ack_match;
  logic              timeout;
  logic              done;
  logic              rsp_err;
  logic [DATA_W-1:0] rsp_data;
  logic              spur_hit;

  // Requester payloads and the one currently granted
  always_comb begin
    m0_pl   = '{is_wr: m0_req_is_wr, addr: m0_addr, wr_data: m0_wr_data, wr_biten: m0_wr_biten};
    m1_pl   = '{is_wr: m1_req_is_wr, addr: m1_addr, wr_data: m1_wr_data, wr_biten: m1_wr_biten};
    sel_pl  = grant_q ? m1_pl : m0_pl;
    sel_req = grant_q ? m1_req : m0_req;
  end

  // Arbitration, handshake and response qualification
  always_comb begin
    win = m1_req;
    if (m0_req && m1_req) begin
      win = (M1_PRIORITY != 0) ? 1'b1 : ~last_grant;
    end
    accept    = (state == ST_FWD) && sel_req &&
                !(sel_pl.is_wr ? regs_req_stall_wr : regs_req_stall_rd);
    ack_match = (state == ST_WAIT) && (txn_is_wr ? regs_wr_ack : regs_rd_ack);
    timeout   = TO_EN && (state == ST_WAIT) && (cnt == TO_LAST);
    done      = ack_match || timeout;
    // A real ack always beats a coincident timeout
    rsp_err   = ack_match ? (txn_is_wr ? regs_wr_err : regs_rd_err) : 1'b1;
    rsp_data  = (ack_match && !txn_is_wr) ? regs_rd_data : '0;
    spur_hit  = (regs_rd_ack && !((state == ST_WAIT) && !txn_is_wr)) ||
                (regs_wr_ack && !((state == ST_WAIT) &&  txn_is_wr));
  end

  // FSM, owner tracking, timeout counter and sticky spurious-ack flag
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state        <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant   <= 1'b1;
      txn_is_wr    <= 1'b0;
      cnt          <= '0;
      spurious_ack <= 1'b0;
    end else begin
      if (spur_hit) begin
        spurious_ack <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (m0_req || m1_req) begin
            grant_q <= win;
            state   <= ST_FWD;
          end
        end
        ST_FWD: begin
          if (accept) begin
            txn_is_wr <= sel_pl.is_wr;
            cnt       <= '0;
            state     <= ST_WAIT;
          end else if (!sel_req) begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (done) begin
            last_grant <= grant_q;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Downstream muxing, stall routing and response steering
  always_comb begin
    m0_req_stall_rd = 1'b1;
    m0_req_stall_wr = 1'b1;
    m1_req_stall_rd = 1'b1;
    m1_req_stall_wr = 1'b1;
    m0_rd_ack       = 1'b0;
    m0_rd_err       = 1'b0;
    m0_rd_data      = '0;
    m0_wr_ack       = 1'b0;
    m0_wr_err       = 1'b0;
    m1_rd_ack       = 1'b0;
    m1_rd_err       = 1'b0;
    m1_rd_data      = '0;
    m1_wr_ack       = 1'b0;
    m1_wr_err       = 1'b0;
    regs_req        = 1'b0;
    regs_req_is_wr  = 1'b0;
    regs_addr       = '0;
    regs_wr_data    = '0;
    regs_wr_biten   = '0;
    busy            = (state != ST_IDLE);
    grant           = (state != ST_IDLE) && grant_q;

    if (state == ST_FWD) begin
      regs_req       = sel_req;
      regs_req_is_wr = sel_pl.is_wr;
      regs_addr      = sel_pl.addr;
      regs_wr_data   = sel_pl.wr_data;
      regs_wr_biten  = sel_pl.wr_biten;
      if (grant_q) begin
        m1_req_stall_rd = regs_req_stall_rd;
        m1_req_stall_wr = regs_req_stall_wr;
      end else begin
        m0_req_stall_rd = regs_req_stall_rd;
        m0_req_stall_wr = regs_req_stall_wr;
      end
    end

    if (done) begin
      if (grant_q) begin
        m1_rd_ack  = !txn_is_wr;
        m1_rd_err  = !txn_is_wr && rsp_err;
        m1_rd_data = rsp_data;
        m1_wr_ack  = txn_is_wr;
        m1_wr_err  = txn_is_wr && rsp_err;
      end else begin
        m0_rd_ack  = !txn_is_wr;
        m0_rd_err  = !txn_is_wr && rsp_err;
        m0_rd_data = rsp_data;
        m0_wr_ack  = txn_is_wr;
        m0_wr_err  = txn_is_wr && rsp_err;
      end
    end
  end

endmodule

// File: tb/tb_hsv_core_ctrlstatus_regs_arbiter.sv
// Randomized bench for the CSR bus arbiter. Two instances run side by side:
// d0 uses fixed m1 priority with a 4-cycle ack timeout, d1 uses round-robin
// with a 6-cycle timeout. Each has its own requesters, downstream and model.
module tb_hsv_core_ctrlstatus_regs_arbiter;

  localparam int unsigned N_CYC = 4000;

  logic clk = 1'b0;
  logic rst;

  // Requester side, indexed [instance][requester]
  logic        rq       [2][2];
  logic        rq_wr    [2][2];
  logic [15:0] rq_addr  [2][2];
  logic [31:0] rq_data  [2][2];
  logic [31:0] rq_biten [2][2];
  logic        o_stall_rd [2][2];
  logic        o_stall_wr [2][2];
  logic        o_rd_ack   [2][2];
  logic        o_rd_err   [2][2];
  logic [31:0] o_rd_data  [2][2];
  logic        o_wr_ack   [2][2];
  logic        o_wr_err   [2][2];

  // Downstream side, indexed [instance]
  logic        r_req   [2];
  logic        r_wr    [2];
  logic [15:0] r_addr  [2];
  logic [31:0] r_wdata [2];
  logic [31:0] r_biten [2];
  logic        ds_stall_rd [2];
  logic        ds_stall_wr [2];
  logic        ds_rd_ack   [2];
  logic        ds_rd_err   [2];
  logic [31:0] ds_rd_data  [2];
  logic        ds_wr_ack   [2];
  logic        ds_wr_err   [2];
  logic        o_grant [2];
  logic        o_busy  [2];
  logic        o_spur  [2];

  // Reference model: phase 0 = idle, 1 = offering to downstream, 2 = awaiting ack
  int  ph    [2];
  bit  own   [2];
  bit  last  [2];
  bit  twr   [2];
  bit  spur  [2];
  int  wcyc  [2];
  bit  acc   [2][2];
  int  to_lim [2] = '{4, 6};
  bit  m1_fix [2] = '{1'b1, 1'b0};

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hsv_core_ctrlstatus_regs_arbiter #(
      .M1_PRIORITY ((g == 0) ? 1 : 0),
      .ACK_TIMEOUT ((g == 0) ? 4 : 6),
      .CNT_W       (8)
    ) u_dut (
      .clk_core          (clk),
      .rst_core          (rst),
      .m0_req            (rq[g][0]),
      .m0_req_is_wr      (rq_wr[g][0]),
      .m0_addr           (rq_addr[g][0]),
      .m0_wr_data        (rq_data[g][0]),
      .m0_wr_biten       (rq_biten[g][0]),
      .m0_req_stall_rd   (o_stall_rd[g][0]),
      .m0_req_stall_wr   (o_stall_wr[g][0]),
      .m0_rd_ack         (o_rd_ack[g][0]),
      .m0_rd_err         (o_rd_err[g][0]),
      .m0_rd_data        (o_rd_data[g][0]),
      .m0_wr_ack         (o_wr_ack[g][0]),
      .m0_wr_err         (o_wr_err[g][0]),
      .m1_req            (rq[g][1]),
      .m1_req_is_wr      (rq_wr[g][1]),
      .m1_addr           (rq_addr[g][1]),
      .m1_wr_data        (rq_data[g][1]),
      .m1_wr_biten       (rq_biten[g][1]),
      .m1_req_stall_rd   (o_stall_rd[g][1]),
      .m1_req_stall_wr   (o_stall_wr[g][1]),
      .m1_rd_ack         (o_rd_ack[g][1]),
      .m1_rd_err         (o_rd_err[g][1]),
      .m1_rd_data        (o_rd_data[g][1]),
      .m1_wr_ack         (o_wr_ack[g][1]),
      .m1_wr_err         (o_wr_err[g][1]),
      .regs_req          (r_req[g]),
      .regs_req_is_wr    (r_wr[g]),
      .regs_addr         (r_addr[g]),
      .regs_wr_data      (r_wdata[g]),
      .regs_wr_biten     (r_biten[g]),
      .regs_req_stall_rd (ds_stall_rd[g]),
      .regs_req_stall_wr (ds_stall_wr[g]),
      .regs_rd_ack       (ds_rd_ack[g]),
      .regs_rd_err       (ds_rd_err[g]),
      .regs_rd_data      (ds_rd_data[g]),
      .regs_wr_ack       (ds_wr_ack[g]),
      .regs_wr_err       (ds_wr_err[g]),
      .grant             (o_grant[g]),
      .busy              (o_busy[g]),
      .spurious_ack      (o_spur[g])
    );
  end

  // Count one comparison and report it if it differs
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of random requester and downstream activity
  task automatic drive(input int cyc);
    rst = (cyc < 2) || ($urandom_range(0, 199) == 0);
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 2; x++) begin
        if (rq[d][x] && !acc[d][x]) begin
          // Unaccepted request is held; occasionally the requester flushes it
          if ($urandom_range(0, 15) == 0) rq[d][x] = 1'b0;
        end else begin
          rq[d][x]       = ($urandom_range(0, 2) != 0);
          rq_wr[d][x]    = ($urandom_range(0, 1) != 0);
          rq_addr[d][x]  = 16'($urandom);
          rq_data[d][x]  = $urandom;
          rq_biten[d][x] = $urandom;
        end
      end
      ds_stall_rd[d] = ($urandom_range(0, 3) == 0);
      ds_stall_wr[d] = ($urandom_range(0, 3) == 0);
      ds_rd_ack[d]   = ($urandom_range(0, 59) == 0);
      ds_wr_ack[d]   = ($urandom_range(0, 59) == 0);
      if (ph[d] == 2 && $urandom_range(0, 2) == 0) begin
        if (twr[d]) ds_wr_ack[d] = 1'b1;
        else        ds_rd_ack[d] = 1'b1;
      end
      ds_rd_err[d]  = ($urandom_range(0, 3) == 0);
      ds_wr_err[d]  = ($urandom_range(0, 3) == 0);
      ds_rd_data[d] = $urandom;
    end
  endtask

  // Compare instance d against the model, then advance the model one clock
  task automatic check_step(input int d);
    bit   g;
    int   p;
    bit   matched, tmo, fin, relevant_stall;
    bit   e_ack;
    string pf;
    g  = own[d];
    p  = ph[d];
    pf = $sformatf("d%0d", d);

    matched = (p == 2) && (twr[d] ? ds_wr_ack[d] : ds_rd_ack[d]);
    tmo     = (p == 2) && (to_lim[d] != 0) && (wcyc[d] == to_lim[d]);
    fin     = matched || tmo;

    chk({pf, ".busy"},  32'(o_busy[d]),  32'(p != 0));
    chk({pf, ".grant"}, 32'(o_grant[d]), 32'((p != 0) && g));
    chk({pf, ".spurious_ack"}, 32'(o_spur[d]), 32'(spur[d]));
    chk({pf, ".regs_req"}, 32'(r_req[d]), 32'((p == 1) && rq[d][g]));
    if (p != 2) begin
      chk({pf, ".regs_is_wr"}, 32'(r_wr[d]), 32'((p == 1) && rq_wr[d][g]));
      chk({pf, ".regs_addr"},  32'(r_addr[d]),  (p == 1) ? 32'(rq_addr[d][g]) : 32'd0);
      chk({pf, ".regs_wdata"}, r_wdata[d], (p == 1) ? rq_data[d][g]  : 32'd0);
      chk({pf, ".regs_biten"}, r_biten[d], (p == 1) ? rq_biten[d][g] : 32'd0);
    end

    for (int x = 0; x < 2; x++) begin
      string t;
      t = $sformatf("d%0d.m%0d", d, x);
      chk({t, ".stall_rd"}, 32'(o_stall_rd[d][x]),
          (p == 1 && x == int'(g)) ? 32'(ds_stall_rd[d]) : 32'd1);
      chk({t, ".stall_wr"}, 32'(o_stall_wr[d][x]),
          (p == 1 && x == int'(g)) ? 32'(ds_stall_wr[d]) : 32'd1);
      e_ack = fin && (x == int'(g)) && !twr[d];
      chk({t, ".rd_ack"},  32'(o_rd_ack[d][x]), 32'(e_ack));
      chk({t, ".rd_err"},  32'(o_rd_err[d][x]), 32'(e_ack && (matched ? ds_rd_err[d] : 1'b1)));
      chk({t, ".rd_data"}, o_rd_data[d][x], (e_ack && matched) ? ds_rd_data[d] : 32'd0);
      e_ack = fin && (x == int'(g)) && twr[d];
      chk({t, ".wr_ack"},  32'(o_wr_ack[d][x]), 32'(e_ack));
      chk({t, ".wr_err"},  32'(o_wr_err[d][x]), 32'(e_ack && (matched ? ds_wr_err[d] : 1'b1)));
    end

    // Requester-side handshake outcome for this cycle
    relevant_stall = rq_wr[d][g] ? ds_stall_wr[d] : ds_stall_rd[d];
    for (int x = 0; x < 2; x++) acc[d][x] = 1'b0;
    acc[d][g] = (p == 1) && rq[d][g] && !relevant_stall;

    if (rst) begin
      ph[d] = 0; own[d] = 1'b0; last[d] = 1'b1; wcyc[d] = 0; spur[d] = 1'b0; twr[d] = 1'b0;
    end else begin
      if ((ds_rd_ack[d] && !(p == 2 && !twr[d])) || (ds_wr_ack[d] && !(p == 2 && twr[d])))
        spur[d] = 1'b1;
      if (p == 0) begin
        if (rq[d][0] || rq[d][1]) begin
          if (rq[d][0] && rq[d][1]) own[d] = m1_fix[d] ? 1'b1 : !last[d];
          else                      own[d] = rq[d][1];
          ph[d] = 1;
        end
      end else if (p == 1) begin
        if (acc[d][g]) begin
          twr[d] = rq_wr[d][g]; wcyc[d] = 1; ph[d] = 2;
        end else if (!rq[d][g]) begin
          ph[d] = 0;
        end
      end else begin
        if (fin) begin
          last[d] = g; ph[d] = 0;
        end else begin
          wcyc[d]++;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      ph[d] = 0; own[d] = 1'b0; last[d] = 1'b1; twr[d] = 1'b0; spur[d] = 1'b0; wcyc[d] = 0;
      ds_stall_rd[d] = 1'b0; ds_stall_wr[d] = 1'b0;
      ds_rd_ack[d] = 1'b0; ds_rd_err[d] = 1'b0; ds_rd_data[d] = '0;
      ds_wr_ack[d] = 1'b0; ds_wr_err[d] = 1'b0;
      for (int x = 0; x < 2; x++) begin
        acc[d][x] = 1'b0; rq[d][x] = 1'b0; rq_wr[d][x] = 1'b0;
        rq_addr[d][x] = '0; rq_data[d][x] = '0; rq_biten[d][x] = '0;
      end
    end
    @(posedge clk);
    for (int cyc = 0; cyc < int'(N_CYC); cyc++) begin
      @(negedge clk);
      drive(cyc);
      #1;
      check_step(0);
      check_step(1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hsv_core_ctrlstatus_regs_arbiter.md
Name: hsv_core_ctrlstatus_regs_arbiter

Overview:
- Two-requester arbiter for the single CSR register-file bus (regs_* protocol).
- Requester m0 is the ctrlstatus read/write unit (CSR instructions); requester m1 is the trap/commit path (mepc/mcause/mtval/mstatus updates).
- Serialises accesses with one outstanding transaction. Routes acks, errors and read data back to the owner.
- Synthesises an error response if the register file never acks.

Parameters:
- M1_PRIORITY, 1, 1 = m1 wins every tie (fixed priority); 0 = round-robin between m0 and m1
- ACK_TIMEOUT, 64, WAIT cycles before a synthetic error ack; 0 disables the timeout
- CNT_W, 8, timeout counter width; must satisfy 2**CNT_W > ACK_TIMEOUT

Ports:
- clk_core  in  1  core clock; single clock domain
- rst_core  in  1  reset, synchronous, active-high
- mX_req (X=0,1)  in  1  requester X access request, held until accepted
- mX_req_is_wr  in  1  1 = write, 0 = read
- mX_addr  in  16  register byte address
- mX_wr_data  in  32  write data
- mX_wr_biten  in  32  write bit enables
- mX_req_stall_rd  out  1  read not accepted this cycle
- mX_req_stall_wr  out  1  write not accepted this cycle
- mX_rd_ack  out  1  read response pulse
- mX_rd_err  out  1  read error, valid with mX_rd_ack
- mX_rd_data  out  32  read data, valid with mX_rd_ack; 0 otherwise
- mX_wr_ack  out  1  write response pulse
- mX_wr_err  out  1  write error, valid with mX_wr_ack
- regs_req, regs_req_is_wr  out  1  downstream request
- regs_addr  out  16  downstream address
- regs_wr_data, regs_wr_biten  out  32  downstream write data / bit enables
- regs_req_stall_rd, regs_req_stall_wr  in  1  downstream stalls
- regs_rd_ack, regs_rd_err  in  1  downstream read response
- regs_rd_data  in  32  downstream read data
- regs_wr_ack, regs_wr_err  in  1  downstream write response
- grant  out  1  current owner: 0 = m0, 1 = m1; meaningful in FWD/WAIT
- busy  out  1  state != IDLE
- spurious_ack  out  1  sticky flag: ack received with no matching outstanding transaction

Behaviour:
- Handshake on each side: a request is accepted in the cycle where req=1 and the relevant stall=0.
  - Fields must be stable while req=1 and the request is unaccepted.
  - Acks are single-cycle pulses, earliest one cycle after acceptance.
- Reset (rst_core sampled high at a clock edge):
  - state=IDLE, grant=0, last_grant=1 (m0 wins the first round-robin tie), timeout counter=0, spurious_ack=0.
  - In IDLE all outputs are 0 except both stall pairs, which are 1.
- FSM states IDLE, FWD, WAIT:
  - IDLE:
    - Both stall pairs=1; regs_req=0.
    - If any mX_req: register the winner into grant and go to FWD (1 cycle arbitration latency).
    - Single requester: that requester wins.
    - Tie: M1_PRIORITY=1 -> m1; otherwise the requester != last_grant.
  - FWD:
    - regs_* fields are muxed from the granted requester; regs_req = m[grant]_req.
    - m[grant] stalls = downstream stalls; the loser's stalls=1.
    - Accepted (regs_req & ~relevant stall): latch is_wr into txn_is_wr, clear the counter, go to WAIT.
    - m[grant]_req drops before acceptance (requester flush): go to IDLE, last_grant unchanged.
  - WAIT:
    - regs_req=0; both stall pairs=1.
    - Counter increments each cycle.
    - Matching ack (regs_rd_ack & ~txn_is_wr, or regs_wr_ack & txn_is_wr): forward ack/err/data to m[grant] combinationally in the same cycle, set last_grant=grant, go to IDLE.
    - Counter == ACK_TIMEOUT-1 with no ack (ACK_TIMEOUT != 0): pulse m[grant] rd_ack or wr_ack with err=1 and rd_data=0, update last_grant, go to IDLE.
- Non-matching ack, or any ack in IDLE/FWD: not forwarded; spurious_ack <= 1. It stays set until reset. A late ack after a timeout is such a case.
- Simultaneous matching ack and timeout expiry in one cycle: the real ack wins; forward its actual err and data.
- Reset mid-transaction: state returns to IDLE immediately. A later downstream ack for the abandoned access sets spurious_ack.
- Non-owner response outputs are always 0.
- Throughput: minimum 3 cycles per access (IDLE, FWD, WAIT with ack on the next cycle). A new arbitration begins in the IDLE cycle following the ack.

Test Plan:
- m0 read of addr 0x3000 alone; downstream stall_rd=0, rd_ack two cycles later with data 0x0000_1800 -> m0 sees stall_rd=1 for 1 cycle, then acceptance; m0_rd_ack pulses once with data 0x0000_1800, rd_err=0; m1 outputs stay 0.
- m0 write and m1 write both asserted from IDLE, M1_PRIORITY=1 -> m1 served first. m0 stall_wr stays 1 until m1_wr_ack, then m0 is granted; downstream sees m1's addr/data before m0's.
- Same contention with M1_PRIORITY=0, three back-to-back rounds -> grant order m0, m1, m0.
- ACK_TIMEOUT=4, m1 read accepted, downstream never acks -> m1_rd_ack with rd_err=1 and rd_data=0 exactly 4 cycles after entering WAIT. A downstream rd_ack 2 cycles later sets spurious_ack=1 and is not forwarded.
- m0 granted, downstream stall_wr=1 for 3 cycles, m0 drops req in cycle 2 -> FSM returns to IDLE with no downstream acceptance; a pending m1_req is granted next.
- Assert rst_core during WAIT -> next cycle busy=0 and both stalls=1; later regs_wr_ack sets spurious_ack and produces no mX_wr_ack.
